// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer: PC generation, in-order memory requests, response/PC pairing, redirect squash.
// Optional perf counters (perf_req_cnt, perf_drop_cnt) when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_ctrl #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h1c000000,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [6:0]                           stall,
  input  logic                                 flush,
  input  logic [ADDR_WIDTH-1:0]                flush_pc,
  input  logic                                 branch_flag_i,
  input  logic [ADDR_WIDTH-1:0]                branch_target_i,
  output logic                                 req_valid,
  output logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic                                 req_ready,
  input  logic                                 rsp_valid,
  input  logic [31:0]                          rsp_data,
  output logic                                 inst_valid,
  output logic [ADDR_WIDTH-1:0]                inst_pc,
  output logic [31:0]                          inst_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_req_cnt,
  output logic [31:0]                          perf_drop_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TW = CW + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  redir_q;

  logic [ADDR_WIDTH-1:0] pcf_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         pcf_rd, pcf_wr;
  logic [CW-1:0]         pcf_cnt, pcf_cnt_n, drop_pend, drop_pend_n;

  logic [ADDR_WIDTH-1:0] rq_pc  [MAX_OUTSTANDING];
  logic [31:0]           rq_dat [MAX_OUTSTANDING];
  logic [PW-1:0]         rq_rd, rq_wr;
  logic [CW-1:0]         rq_cnt, rq_cnt_n;

  logic [TW-1:0]         total, total_n;
  logic                  redirect, accept, rsp_take, rsp_drop, rsp_live;
  logic                  out_load, out_from_q, out_bypass, rq_push;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  unused_stall;

  assign unused_stall = ^stall[6:3];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect  = flush | branch_flag_i;
  assign redir_pc  = flush ? flush_pc : branch_target_i;
  assign total     = {1'b0, pcf_cnt} + {1'b0, rq_cnt};
  assign req_valid = (state == S_FETCH) && !redir_q && (total < TW'(MAX_OUTSTANDING));
  assign req_addr  = pc;
  assign accept    = req_valid && req_ready;

  // A response landing in the redirect cycle is squashed along with the queue.
  assign rsp_take   = rsp_valid && (pcf_cnt != '0);
  assign rsp_drop   = rsp_take && ((drop_pend != '0) || redirect);
  assign rsp_live   = rsp_take && !rsp_drop;
  assign out_load   = !stall[1] && !redirect;
  assign out_from_q = out_load && (rq_cnt != '0);
  assign out_bypass = out_load && (rq_cnt == '0) && rsp_live;
  assign rq_push    = rsp_live && !out_bypass && !redirect;

  assign outstanding = pcf_cnt - drop_pend;

  always_comb begin
    pcf_cnt_n   = pcf_cnt + CW'(accept) - CW'(rsp_take);
    rq_cnt_n    = redirect ? '0 : rq_cnt + CW'(rq_push) - CW'(out_from_q);
    drop_pend_n = redirect ? pcf_cnt_n
                           : drop_pend - CW'(rsp_take && (drop_pend != '0));
    total_n     = {1'b0, pcf_cnt_n} + {1'b0, rq_cnt_n};
    state_n     = state;
    case (state)
      S_BOOT:  state_n = S_FETCH;
      // A presented but unaccepted request keeps FETCH so req_valid stays stable.
      S_FETCH: if ((stall[0] || total_n >= TW'(MAX_OUTSTANDING)) && !(req_valid && !req_ready))
                 state_n = S_HOLD;
      S_HOLD:  if (!stall[0] && total_n < TW'(MAX_OUTSTANDING))
                 state_n = S_FETCH;
      default: state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) pcf_mem[pcf_wr] <= pc;
    if (rq_push) begin
      rq_pc[rq_wr]  <= pcf_mem[pcf_rd];
      rq_dat[rq_wr] <= rsp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      redir_q    <= 1'b0;
      pcf_rd     <= '0;
      pcf_wr     <= '0;
      pcf_cnt    <= '0;
      drop_pend  <= '0;
      rq_rd      <= '0;
      rq_wr      <= '0;
      rq_cnt     <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_o     <= '0;
    end else begin
      state     <= state_n;
      redir_q   <= redirect;
      pcf_cnt   <= pcf_cnt_n;
      drop_pend <= drop_pend_n;
      rq_cnt    <= rq_cnt_n;
      if (redirect)    pc <= redir_pc;
      else if (accept) pc <= pc + ADDR_WIDTH'(4);
      if (accept)   pcf_wr <= ptr_inc(pcf_wr);
      if (rsp_take) pcf_rd <= ptr_inc(pcf_rd);
      if (redirect) begin
        rq_rd <= '0;
        rq_wr <= '0;
      end else begin
        if (rq_push)    rq_wr <= ptr_inc(rq_wr);
        if (out_from_q) rq_rd <= ptr_inc(rq_rd);
      end
      if (redirect) begin
        inst_valid <= 1'b0;
      end else if (!stall[1]) begin
        if (out_from_q) begin
          inst_valid <= 1'b1;
          inst_pc    <= rq_pc[rq_rd];
          inst_o     <= rq_dat[rq_rd];
        end else if (out_bypass) begin
          inst_valid <= 1'b1;
          inst_pc    <= pcf_mem[pcf_rd];
          inst_o     <= rsp_data;
        end else begin
          inst_valid <= 1'b0;
        end
      end else if (!stall[2]) begin
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_req_cnt  <= '0;
      perf_drop_cnt <= '0;
    end else begin
      if (accept)   perf_req_cnt  <= perf_req_cnt + 32'd1;
      if (rsp_drop) perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a latency-1 in-order memory model (data = ~addr).
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_o;
  logic [1:0]  outstanding;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_req_cnt, perf_drop_cnt;
`endif

  int total = 0;
  int passed = 0;
  logic mem_en = 1'b1;
  logic [31:0] mq[$];

  if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_o(inst_o),
    .outstanding(outstanding)
`ifdef IF_FETCH_PERF_CNT_EN
    , .perf_req_cnt(perf_req_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive_rsp();
    rsp_valid = mem_en && (mq.size() > 0);
    rsp_data  = (mq.size() > 0) ? ~mq[0] : 32'h0;
  endtask

  task automatic tick();
    logic acc, fired;
    logic [31:0] a;
    @(negedge clk);
    acc = req_valid && req_ready;
    a = req_addr;
    fired = rsp_valid;
    @(posedge clk);
    #1;
    if (fired && mq.size() > 0) mq.delete(0);
    if (acc) mq.push_back(a);
    drive_rsp();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = '0; flush = 1'b0; branch_flag_i = 1'b0; req_ready = 1'b1;
    mem_en = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", req_valid); else passed++;
    total++; if (req_addr !== 32'h1c000000) $display("FAIL reset_req_addr: got %h want 1c000000", req_addr); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid); else passed++;
    total++; if (inst_pc !== 32'h0 || inst_o !== 32'h0) $display("FAIL reset_inst: got pc %h o %h want 0 0", inst_pc, inst_o); else passed++;
    total++; if (outstanding !== 2'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else passed++;
  endtask

  task automatic test_basic_fetch();
    logic [31:0] exp_pc;
    do_reset();
    // stray response with nothing in flight must be ignored
    rsp_valid = 1'b1; rsp_data = 32'h12345678;
    total++; if (req_valid !== 1'b0) $display("FAIL boot_req_valid: got %b want 0", req_valid); else passed++;
    tick();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h1c000000) $display("FAIL first_req: got v%b %h want v1 1c000000", req_valid, req_addr); else passed++;
    total++; if (inst_valid !== 1'b0 || outstanding !== 2'd0) $display("FAIL stray_rsp: got v%b out %0d want v0 out 0", inst_valid, outstanding); else passed++;
    tick();
    total++; if (outstanding !== 2'd1 || req_addr !== 32'h1c000004) $display("FAIL first_accept: got out %0d addr %h want 1 1c000004", outstanding, req_addr); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = 32'h1c000000 + 32'(i * 4);
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_o !== ~exp_pc)
        $display("FAIL stream_%0d: got v%b pc %h o %h want v1 pc %h o %h", i, inst_valid, inst_pc, inst_o, exp_pc, ~exp_pc);
      else passed++;
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    req_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (req_valid !== 1'b1 || req_addr !== 32'h1c000000)
        $display("FAIL ready_low_%0d: got v%b %h want v1 1c000000", i, req_valid, req_addr);
      else passed++;
    end
    req_ready = 1'b1;
    tick();
    total++; if (req_addr !== 32'h1c000004) $display("FAIL ready_release: got %h want 1c000004", req_addr); else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    mem_en = 1'b0;
    tick(); tick(); tick();
    total++; if (outstanding !== 2'd2 || req_valid !== 1'b0) $display("FAIL br_inflight: got out %0d v%b want 2 v0", outstanding, req_valid); else passed++;
    branch_flag_i = 1'b1; branch_target_i = 32'h1c000100;
    tick();
    branch_flag_i = 1'b0;
    total++; if (outstanding !== 2'd0 || req_valid !== 1'b0) $display("FAIL br_marked: got out %0d v%b want 0 v0", outstanding, req_valid); else passed++;
    mem_en = 1'b1;
    drive_rsp();
    tick();
    total++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h1c000100) $display("FAIL br_refetch: got iv%b v%b %h want iv0 v1 1c000100", inst_valid, req_valid, req_addr); else passed++;
    tick();
    total++; if (inst_valid !== 1'b0) $display("FAIL br_drop2: got %b want 0", inst_valid); else passed++;
`ifdef IF_FETCH_PERF_CNT_EN
    total++; if (perf_drop_cnt !== 32'd2 || perf_req_cnt !== 32'd3) $display("FAIL br_perf: got drop %0d req %0d want 2 3", perf_drop_cnt, perf_req_cnt); else passed++;
`endif
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000100 || inst_o !== ~32'h1c000100) $display("FAIL br_target: got v%b pc %h o %h want v1 1c000100", inst_valid, inst_pc, inst_o); else passed++;
  endtask

  task automatic test_flush_priority();
    do_reset();
    tick();
    flush = 1'b1; flush_pc = 32'h1c000800;
    branch_flag_i = 1'b1; branch_target_i = 32'h1c000100;
    tick();
    flush = 1'b0; branch_flag_i = 1'b0;
    total++; if (req_valid !== 1'b0 || outstanding !== 2'd0) $display("FAIL fl_bubble: got v%b out %0d want v0 0", req_valid, outstanding); else passed++;
    tick();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h1c000800 || inst_valid !== 1'b0) $display("FAIL fl_target: got v%b %h iv%b want v1 1c000800 iv0", req_valid, req_addr, inst_valid); else passed++;
    tick(); tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000800) $display("FAIL fl_inst: got v%b pc %h want v1 1c000800", inst_valid, inst_pc); else passed++;
`ifdef IF_FETCH_PERF_CNT_EN
    total++; if (perf_drop_cnt !== 32'd1) $display("FAIL fl_perf: got %0d want 1", perf_drop_cnt); else passed++;
`endif
  endtask

  task automatic test_hold_stall();
    do_reset();
    tick(); tick(); tick();
    total++; if (inst_pc !== 32'h1c000000 || inst_valid !== 1'b1) $display("FAIL hold_pre: got v%b pc %h want v1 1c000000", inst_valid, inst_pc); else passed++;
    stall = 7'b0000110;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000000 || inst_o !== ~32'h1c000000)
        $display("FAIL hold_%0d: got v%b pc %h want v1 1c000000", i, inst_valid, inst_pc);
      else passed++;
    end
    total++; if (outstanding !== 2'd0 || req_valid !== 1'b0) $display("FAIL hold_full: got out %0d v%b want 0 v0", outstanding, req_valid); else passed++;
    stall = '0;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000004 || inst_o !== ~32'h1c000004) $display("FAIL hold_rel0: got v%b pc %h want v1 1c000004", inst_valid, inst_pc); else passed++;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000008) $display("FAIL hold_rel1: got v%b pc %h want v1 1c000008", inst_valid, inst_pc); else passed++;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c00000c) $display("FAIL hold_rel2: got v%b pc %h want v1 1c00000c", inst_valid, inst_pc); else passed++;
  endtask

  task automatic test_bubble();
    do_reset();
    tick(); tick(); tick();
    stall = 7'b0000010;
    tick();
    total++; if (inst_valid !== 1'b0) $display("FAIL bubble: got %b want 0", inst_valid); else passed++;
    stall = '0;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000004) $display("FAIL bubble_q0: got v%b pc %h want v1 1c000004", inst_valid, inst_pc); else passed++;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1c000008) $display("FAIL bubble_q1: got v%b pc %h want v1 1c000008", inst_valid, inst_pc); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    branch_flag_i = 1'b1; branch_target_i = 32'hfffffffc;
    tick();
    branch_flag_i = 1'b0;
    tick();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'hfffffffc) $display("FAIL wrap_top: got v%b %h want v1 fffffffc", req_valid, req_addr); else passed++;
    tick();
    total++; if (req_addr !== 32'h0) $display("FAIL wrap_zero: got %h want 00000000", req_addr); else passed++;
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hfffffffc || inst_o !== 32'h3) $display("FAIL wrap_inst: got v%b pc %h o %h want v1 fffffffc 00000003", inst_valid, inst_pc, inst_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_ready_low();
    test_branch();
    test_flush_priority();
    test_hold_stall();
    test_bubble();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequences instruction fetch in front of the IF/ID stage: generates the PC, issues in-order read requests to the instruction memory over a valid/ready handshake, and pairs each returned word with its PC.
- Handles branch redirect, flush redirect and the 7-bit pipeline stall vector.
- Discards responses belonging to a squashed PC stream.
- Its inst_valid/inst_pc/inst_o outputs feed the IF/ID register directly.

Parameters:
- ADDR_WIDTH, 32, width of PC and request address.
- RESET_PC, 32'h1c000000, first fetch address after reset.
- MAX_OUTSTANDING, 2, maximum in-flight requests (power of 2, >=1); also the response queue depth.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  7  pipeline stall vector; stall[0]=1 freezes PC generation, stall[1]=1 freezes the fetch output.
- flush  in  1  exception/ertn flush.
- flush_pc  in  ADDR_WIDTH  redirect target when flush=1.
- branch_flag_i  in  1  branch taken, from EX.
- branch_target_i  in  ADDR_WIDTH  branch target.
- req_valid  out  1  fetch request valid.
- req_addr  out  ADDR_WIDTH  fetch address, word aligned.
- req_ready  in  1  memory accepts request.
- rsp_valid  in  1  response word valid; responses return in request order, never before the accepting cycle+1.
- rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction output valid.
- inst_pc  out  ADDR_WIDTH  PC of inst_o.
- inst_o  out  32  instruction word.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  live in-flight count, excluding requests marked for drop.

Behaviour:
- Reset (async) values:
  - pc=RESET_PC; req_valid=0; req_addr=RESET_PC.
  - inst_valid=0; inst_pc=0; inst_o=0.
  - All counters and queues cleared; state=BOOT.
- FSM:
  - BOOT: one cycle after rst deasserts, then goes to FETCH.
  - FETCH: issues requests.
  - HOLD: entered when stall[0]=1, or when in-flight + queued == MAX_OUTSTANDING. Returns to FETCH when neither condition holds.
- Request issue:
  - req_valid=1 in FETCH with req_addr=pc.
  - A request is accepted on req_valid&&req_ready. On acceptance, pc<=pc+4 and req_addr is pushed into the PC FIFO.
  - req_addr and req_valid stay stable until accepted, unless a redirect occurs.
- Redirect priority is flush > branch_flag_i > stall. A redirect in cycle N:
  - pc<=flush_pc (or branch_target_i).
  - Every request in flight at the N posedge is marked drop. A request accepted in cycle N itself is also marked drop.
  - The response queue and inst_valid are cleared at the N posedge.
  - req_valid is deasserted for cycle N+1. Fetch of the new pc starts at N+2.
- Response handling:
  - Each rsp_valid pops the PC FIFO head.
  - If the head is marked drop, the response is discarded.
  - Otherwise {pc, rsp_data} is pushed into the response queue.
  - rsp_valid with an empty PC FIFO is a protocol error: ignored, no state change.
- Output:
  - When stall[1]=0: inst_valid/inst_pc/inst_o load from the queue head (pop), or a same-cycle bypass of the response when the queue is empty. inst_valid=0 if nothing is available.
  - When stall[1]=1 and stall[2]=0: outputs clear to invalid (bubble), no pop.
  - When stall[1]=1 and stall[2]=1: outputs hold.
- Boundaries:
  - The queue never overflows, because issue is gated by in-flight+queued < MAX_OUTSTANDING.
  - Simultaneous accept and response update the counter by net 0.
  - A redirect with the PC FIFO empty only changes pc.
  - pc wraps modulo 2^ADDR_WIDTH.
  - rst mid-transfer drops all state; responses returning after reset are ignored per the protocol-error rule.

Optional Feature:
- Macro IF_FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_req_cnt[31:0] and perf_drop_cnt[31:0].
  - perf_req_cnt increments per accepted request.
  - perf_drop_cnt increments per discarded response.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; other behaviour identical.

Test Plan:
- Reset release, req_ready=1, memory latency 1 -> first req_addr=0x1c000000 the cycle after BOOT; inst_pc sequence 0x1c000000, 0x1c000004, 0x1c000008 with matching rsp_data.
- req_ready=0 for 3 cycles -> req_valid stays 1 and req_addr stays 0x1c000000; pc does not advance.
- Two requests in flight (0x1c000000, 0x1c000004), branch_flag_i=1 with target 0x1c000100 -> both responses discarded, inst_valid stays 0; next inst_pc=0x1c000100; perf_drop_cnt=2 with macro defined.
- flush=1 and branch_flag_i=1 same cycle, flush_pc=0x1c000800, branch_target_i=0x1c000100 -> next fetch address 0x1c000800.
- stall[1]=1 and stall[2]=1 for 4 cycles while 2 responses arrive -> outputs hold, outstanding reaches 0, req_valid=0 (queue full); on release the queued PCs emit in order, one per cycle.
- stall[1]=1 and stall[2]=0 -> inst_valid=0 the next cycle, queue untouched.
